// File: rtl/moka_pkg.sv
// Shared types and defaults for the moka memory arbiter.
// Holds the FSM state encoding, the owner encoding and the default widths.
package moka_pkg;

  localparam int unsigned DefAddrWidth   = 32;
  localparam int unsigned DefDataWidth   = 32;
  localparam int unsigned DefStarveLimit = 4;

  // Wide enough for the largest allowed starvation limit (15).
  localparam int unsigned CntWidth = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StResp = 2'b10
  } state_e;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnLs = 1'b1
  } owner_e;

endpackage

// File: rtl/moka_arb_prio.sv
// Fixed LS-over-IF priority with a saturating starvation counter.
// When IF has lost STARVE_LIMIT contended rounds in a row, it wins the next contended round.
module moka_arb_prio
  import moka_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DefStarveLimit
) (
  input  logic clk,
  input  logic rstn,
  input  logic grant_en,
  input  logic if_req,
  input  logic ls_req,
  output logic grant_valid,
  output logic grant_ls
);

  localparam logic [CntWidth-1:0] LimitCnt = CntWidth'(STARVE_LIMIT);

  logic [CntWidth-1:0] r_cnt;
  logic                w_force_if;

  assign w_force_if  = (r_cnt == LimitCnt) && if_req && ls_req;
  assign grant_valid = grant_en && (if_req || ls_req);
  assign grant_ls    = ls_req && !w_force_if;

  // Only LS grants that actually beat a pending IF request count as starvation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (grant_valid) begin
      if (!grant_ls) begin
        r_cnt <= '0;
      end else if (if_req && (r_cnt != LimitCnt)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/moka_mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter onto one shared memory port.
// One transaction at a time: IDLE grants, BUSY waits for mem_ack, RESP pulses the owner's ready.
module moka_mem_arbiter
  import moka_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned STARVE_LIMIT = DefStarveLimit
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_ready,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [DATA_WIDTH/8-1:0] ls_be,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic [DATA_WIDTH-1:0]   ls_wdata,
  output logic [DATA_WIDTH-1:0]   ls_rdata,
  output logic                    ls_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  state_e                  r_state;
  owner_e                  r_owner;
  logic                    r_mem_req;
  logic                    r_mem_we;
  logic [DATA_WIDTH/8-1:0] r_mem_be;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic [DATA_WIDTH-1:0]   r_if_rdata;
  logic [DATA_WIDTH-1:0]   r_ls_rdata;
  logic                    r_if_ready;
  logic                    r_ls_ready;

  logic w_grant_en;
  logic w_grant_valid;
  logic w_grant_ls;

  assign w_grant_en = (r_state == StIdle) && en;

  moka_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk         (clk),
    .rstn        (rstn),
    .grant_en    (w_grant_en),
    .if_req      (if_req),
    .ls_req      (ls_req),
    .grant_valid (w_grant_valid),
    .grant_ls    (w_grant_ls)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_owner     <= OwnIf;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
      r_if_ready  <= 1'b0;
      r_ls_ready  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_grant_valid) begin
            r_mem_req <= 1'b1;
            r_state   <= StBusy;
            if (w_grant_ls) begin
              r_owner     <= OwnLs;
              r_mem_we    <= ls_we;
              r_mem_be    <= ls_be;
              r_mem_addr  <= ls_addr;
              r_mem_wdata <= ls_wdata;
            end else begin
              r_owner     <= OwnIf;
              r_mem_we    <= 1'b0;
              r_mem_be    <= '1;
              r_mem_addr  <= if_addr;
              r_mem_wdata <= '0;
            end
          end
        end
        StBusy: begin
          // mem_* stay frozen until the memory acknowledges.
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= StResp;
            if (r_owner == OwnIf) begin
              r_if_rdata <= mem_rdata;
              r_if_ready <= 1'b1;
            end else begin
              if (!r_mem_we) begin
                r_ls_rdata <= mem_rdata;
              end
              r_ls_ready <= 1'b1;
            end
          end
        end
        StResp: begin
          r_if_ready <= 1'b0;
          r_ls_ready <= 1'b0;
          r_state    <= StIdle;
        end
        default: begin
          r_mem_req  <= 1'b0;
          r_if_ready <= 1'b0;
          r_ls_ready <= 1'b0;
          r_state    <= StIdle;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_ready  = r_if_ready;
  assign ls_rdata  = r_ls_rdata;
  assign ls_ready  = r_ls_ready;

endmodule

// File: tb/tb_moka_mem_arbiter.sv
// Directed bench for moka_mem_arbiter: memory model with programmable ack latency,
// scoreboard of expected completions popped on every ready pulse.
module tb_moka_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_ready;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  moka_mem_arbiter #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_be     (ls_be),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_rdata  (ls_rdata),
    .ls_ready  (ls_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model: ack after ack_delay cycles of mem_req; force_ack injects spurious acks.
  int          ack_delay = 0;
  int          busy_cnt  = 0;
  logic        force_ack = 1'b0;
  logic [31:0] rd_val    = '0;

  assign mem_rdata = rd_val;
  assign mem_ack   = force_ack || (mem_req && (busy_cnt >= ack_delay));

  always @(posedge clk or negedge rstn) begin
    if (!rstn)         busy_cnt <= 0;
    else if (!mem_req) busy_cnt <= 0;
    else               busy_cnt <= busy_cnt + 1;
  end

  typedef struct {
    logic        is_ls;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic is_ls, input logic [31:0] data);
    exp_t e;
    e.is_ls = is_ls;
    e.data  = data;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn && (if_ready || ls_ready)) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", {30'b0, if_ready, ls_ready}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ready_owner", {30'b0, if_ready, ls_ready}, e.is_ls ? 32'd1 : 32'd2);
        check("resp_rdata", e.is_ls ? ls_rdata : if_rdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks after the grant edge until a ready is seen; then the pulse must be one cycle wide.
  task automatic wait_ready(input int lat);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(if_ready || ls_ready) && n < 20);
    check("ready_latency", n, lat);
    tick();
    check("ready_one_cycle", {30'b0, if_ready, ls_ready}, 32'd0);
  endtask

  initial begin
    int   n;
    int   seen;
    int   model_cnt;
    logic exp_ls;

    rstn = 1'b0; en = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
    #12;
    check("rst_mem_req", mem_req, 0);
    check("rst_ready", {30'b0, if_ready, ls_ready}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    rstn = 1'b1; en = 1'b1;

    // Single IF read, ack one cycle after mem_req.
    ack_delay = 1; rd_val = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 32'h100;
    push_exp(1'b0, 32'hDEADBEEF);
    tick();
    check("if_mem_req", mem_req, 1);
    check("if_mem_addr", mem_addr, 32'h100);
    check("if_mem_we", mem_we, 0);
    check("if_mem_be", mem_be, 4'hF);
    check("if_mem_wdata", mem_wdata, 0);
    if_req = 1'b0;
    wait_ready(2);
    check("if_rdata_hold", if_rdata, 32'hDEADBEEF);

    // LS read, two-cycle ack latency.
    ack_delay = 2; rd_val = 32'hCAFEF00D;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h300;
    push_exp(1'b1, 32'hCAFEF00D);
    tick();
    check("lsr_mem_addr", mem_addr, 32'h300);
    ls_req = 1'b0;
    wait_ready(3);

    // LS write, zero-latency ack: ls_rdata must keep the previous load value.
    ack_delay = 0; rd_val = 32'hBAD0BAD0;
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h200; ls_wdata = 32'h12345678;
    push_exp(1'b1, 32'hCAFEF00D);
    tick();
    check("lsw_mem_we", mem_we, 1);
    check("lsw_mem_be", mem_be, 4'b0011);
    check("lsw_mem_addr", mem_addr, 32'h200);
    check("lsw_mem_wdata", mem_wdata, 32'h12345678);
    ls_req = 1'b0; ls_we = 1'b0;
    wait_ready(1);
    check("if_rdata_hold2", if_rdata, 32'hDEADBEEF);

    // Both requesting continuously: starvation pattern.
    rd_val = 32'h11112222; if_addr = 32'h400; ls_addr = 32'h500; ls_be = 4'hF;
    if_req = 1'b1; ls_req = 1'b1;
    model_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (mem_req !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      if (model_cnt == LIMIT) begin
        exp_ls = 1'b0; model_cnt = 0;
      end else begin
        exp_ls = 1'b1; model_cnt = model_cnt + 1;
      end
      check("grant_order", mem_addr, exp_ls ? 32'h500 : 32'h400);
      push_exp(exp_ls, 32'h11112222);
      tick();
    end
    if_req = 1'b0; ls_req = 1'b0;
    tick();
    tick();

    // Enable low blocks grants; LS wins when it comes back.
    en = 1'b0; if_req = 1'b1; ls_req = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (mem_req !== 1'b0) seen++;
    end
    check("en_block", seen, 0);
    push_exp(1'b1, 32'h11112222);
    en = 1'b1;
    tick();
    check("en_mem_req", mem_req, 1);
    check("en_ls_first", mem_addr, 32'h500);
    if_req = 1'b0; ls_req = 1'b0;
    wait_ready(1);

    // Spurious acks in IDLE and in RESP.
    force_ack = 1'b1;
    repeat (3) tick();
    check("idle_ack_req", mem_req, 0);
    check("idle_ack_ready", {30'b0, if_ready, ls_ready}, 0);
    force_ack = 1'b0;
    if_req = 1'b1; if_addr = 32'h600;
    push_exp(1'b0, 32'h11112222);
    tick();
    if_req = 1'b0;
    tick();
    check("resp_if_ready", if_ready, 1);
    force_ack = 1'b1;
    tick();
    check("resp_ack_ready", {30'b0, if_ready, ls_ready}, 0);
    check("resp_ack_req", mem_req, 0);
    tick();
    check("resp_ack_ready2", {30'b0, if_ready, ls_ready}, 0);
    force_ack = 1'b0;

    // Reset in the middle of a stalled LS transaction.
    ack_delay = 1000;
    if_req = 1'b1; ls_req = 1'b1;
    tick();
    check("pre_rst_req", mem_req, 1);
    check("pre_rst_cnt", dut.u_prio.r_cnt, 1);
    #2 rstn = 1'b0;
    #1;
    check("rst_async_req", mem_req, 0);
    check("rst_async_ready", {30'b0, if_ready, ls_ready}, 0);
    check("rst_async_addr", mem_addr, 0);
    check("rst_async_cnt", dut.u_prio.r_cnt, 0);
    check("rst_async_rdata", ls_rdata, 0);
    ack_delay = 0;
    tick();
    tick();
    @(negedge clk);
    rstn = 1'b1;
    push_exp(1'b1, 32'h11112222);
    tick();
    check("post_rst_grant", mem_req, 1);
    check("post_rst_ls", mem_addr, 32'h500);
    if_req = 1'b0; ls_req = 1'b0;
    wait_ready(1);
    tick();

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
